// File: rtl/piano_pkg.sv
// -----------------------------------------------------------------------------
// piano_pkg
// Shared definitions for the electronic-piano keypad path.
//   NUM_ROWS / NUM_COLS / KEY_W : matrix geometry and key code width
//   KEY_NONE                    : 5-bit frame result meaning "no key closed"
//   deb_state_t                 : debounce FSM states
//   first_key()                 : lowest-index closed key, or KEY_NONE
// -----------------------------------------------------------------------------
package piano_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // MSB set marks "no key"; a real key keeps the MSB clear
    localparam logic [KEY_W:0] KEY_NONE = 5'b1_0000;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_PEND,
        HELD,
        RELEASE_PEND
    } deb_state_t;

    // Walking from the top index down lets the lowest closed key win
    function automatic logic [KEY_W:0] first_key(input logic [NUM_KEYS-1:0] closed);
        logic [KEY_W:0] result;
        result = KEY_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (closed[i]) begin
                result = {1'b0, KEY_W'(i)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// -----------------------------------------------------------------------------
// keypad_scan_if
// Bundles the key matrix pins and the debounced key outputs.
//   row_in    : matrix rows, active-low, asynchronous
//   col_out   : column drive, active-low, one-hot-low
//   key_code  : debounced key code (col*4+row), 0 when no key is valid
//   key_valid : high while a debounced key is held
//   key_press : one-cycle pulse when a new key is accepted
// master = the scanner, slave = the matrix / tone-stage side.
// -----------------------------------------------------------------------------
interface keypad_scan_if;
    import piano_pkg::*;

    logic [NUM_ROWS-1:0] row_in;
    logic [NUM_COLS-1:0] col_out;
    logic [KEY_W-1:0]    key_code;
    logic                key_valid;
    logic                key_press;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_press
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_press
    );

endinterface

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Debounces one full-matrix frame result per frame_done pulse and owns the
// key outputs.
//   inclk        : system clock
//   rst          : synchronous reset, active-high
//   frame_done   : one-cycle strobe, frame_result is valid
//   frame_result : lowest closed key code, or KEY_NONE
//   key_code     : debounced key code, 0 when key_valid=0
//   key_valid    : high while a debounced key is held
//   key_press    : one-cycle pulse on acceptance of a new key
// -----------------------------------------------------------------------------
module keypad_debounce
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic             inclk,
    input  logic             rst,
    input  logic             frame_done,
    input  logic [KEY_W:0]   frame_result,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_FRAMES) + 1;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    deb_state_t       state, state_n;
    logic [KEY_W-1:0] cand, cand_n;
    logic [KEY_W-1:0] key_code_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             key_valid_n, key_press_n;
    logic             is_none, match_cand, match_held;

    assign is_none    = frame_result[KEY_W];
    assign match_cand = !is_none && (frame_result[KEY_W-1:0] == cand);
    assign match_held = !is_none && (frame_result[KEY_W-1:0] == key_code);
    assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // State and output registers
    always_ff @(posedge inclk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_press <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_press <= key_press_n;
        end
    end

    // Next state; nothing moves except on a frame boundary, and key_code is
    // only rewritten on entry to HELD or return to IDLE so it stays frozen
    // for the whole time key_valid is high.
    always_comb begin
        state_n     = state;
        cand_n      = cand;
        cnt_n       = cnt;
        key_code_n  = key_code;
        key_valid_n = key_valid;
        key_press_n = 1'b0;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (!is_none) begin
                        state_n = PRESS_PEND;
                        cand_n  = frame_result[KEY_W-1:0];
                        cnt_n   = CNT_ONE;
                    end
                end
                PRESS_PEND: begin
                    if (is_none) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (match_cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= CNT_DONE) begin
                            state_n     = HELD;
                            key_code_n  = cand;
                            key_valid_n = 1'b1;
                            key_press_n = 1'b1;
                        end
                    end else begin
                        cand_n = frame_result[KEY_W-1:0];
                        cnt_n  = CNT_ONE;
                    end
                end
                HELD: begin
                    if (!match_held) begin
                        state_n = RELEASE_PEND;
                        cnt_n   = CNT_ONE;
                    end
                end
                RELEASE_PEND: begin
                    if (match_held) begin
                        state_n = HELD;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= CNT_DONE) begin
                            state_n     = IDLE;
                            key_valid_n = 1'b0;
                            key_code_n  = '0;
                            cnt_n       = '0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// Scans a 4x4 active-low key matrix, one column per SCAN_DIV cycles, forms
// one result per full frame and hands it to keypad_debounce.
//   inclk : 50 MHz system clock
//   rst   : synchronous reset, active-high
//   bus   : keypad_scan_if.master (row_in, col_out, key_code, key_valid,
//           key_press)
// Parameters: SCAN_DIV (>= 4) cycles per column, DEBOUNCE_FRAMES (>= 2).
// -----------------------------------------------------------------------------
module keypad_scan
    import piano_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic                 inclk,
    input  logic                 rst,
    keypad_scan_if.master        bus
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [NUM_ROWS-1:0] row_meta, row_sync, closed_now;
    logic [DIV_W-1:0]    div_cnt;
    logic [1:0]          col_idx;
    logic [NUM_COLS-1:0] col_out_r;
    logic [11:0]         row_acc;
    logic [KEY_W:0]      frame_result;
    logic                frame_done;

    assign closed_now  = ~row_sync;
    assign bus.col_out = col_out_r;

    // Rows are sampled late in each column slot, so the synchronizer has
    // settled on the newly driven column by the time they are captured.
    // Columns 0..2 accumulate; the column 3 capture completes the frame and
    // clears the accumulator for the next one.
    always_ff @(posedge inclk) begin
        if (rst) begin
            row_meta     <= '1;
            row_sync     <= '1;
            div_cnt      <= '0;
            col_idx      <= '0;
            col_out_r    <= 4'b1110;
            row_acc      <= '0;
            frame_result <= KEY_NONE;
            frame_done   <= 1'b0;
        end else begin
            row_meta   <= bus.row_in;
            row_sync   <= row_meta;
            frame_done <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                col_idx   <= col_idx + 2'd1;
                col_out_r <= ~(NUM_COLS'(1) << (col_idx + 2'd1));
                case (col_idx)
                    2'd0: row_acc[3:0]  <= closed_now;
                    2'd1: row_acc[7:4]  <= closed_now;
                    2'd2: row_acc[11:8] <= closed_now;
                    default: begin
                        frame_result <= first_key({closed_now, row_acc});
                        frame_done   <= 1'b1;
                        row_acc      <= '0;
                    end
                endcase
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .inclk        (inclk),
        .rst          (rst),
        .frame_done   (frame_done),
        .frame_result (frame_result),
        .key_code     (bus.key_code),
        .key_valid    (bus.key_valid),
        .key_press    (bus.key_press)
    );

endmodule
